// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states and the default operand width.
package arith_pkg;

  localparam int ARITH_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    OP,
    FIX,
    NOTIFY
  } div_state_t;

endpackage

// File: rtl/divi_seq_if.sv
// START/END handshake and operand/result bus shared by the sequential arithmetic blocks.
interface divi_seq_if import arith_pkg::*; #(
  parameter int tamano = ARITH_W_DEFAULT
);

  logic              START;
  logic [tamano-1:0] A;
  logic [tamano-1:0] B;
  logic [tamano-1:0] Q;
  logic [tamano-1:0] R;
  logic              END_DIV;
  logic              DIV_ZERO;

  modport master (
    output START, A, B,
    input  Q, R, END_DIV, DIV_ZERO
  );

  modport slave (
    input  START, A, B,
    output Q, R, END_DIV, DIV_ZERO
  );

endinterface

// File: rtl/divi_step.sv
// One restoring-division step: shift {rem,quo} left, then subtract |B| when it fits.
module divi_step import arith_pkg::*; #(
  parameter int tamano = ARITH_W_DEFAULT
) (
  input  logic [tamano:0]   rem,
  input  logic [tamano-1:0] quo,
  input  logic [tamano-1:0] abs_b,
  output logic [tamano:0]   rem_next,
  output logic [tamano-1:0] quo_next
);

  logic [tamano+1:0] rem_sh;
  logic [tamano+1:0] divisor;
  logic              fits;

  // The extra top bit keeps the shifted remainder exact, so the compare never wraps.
  always_comb begin
    rem_sh   = {rem, quo[tamano-1]};
    divisor  = {2'b00, abs_b};
    fits     = (rem_sh >= divisor);
    rem_next = fits ? (tamano+1)'(rem_sh - divisor) : (tamano+1)'(rem_sh);
    quo_next = {quo[tamano-2:0], fits};
  end

endmodule

// File: rtl/divi_seq.sv
// Sequential signed divider: Q = A/B truncated toward zero, R = A - Q*B, one quotient bit per cycle.
module divi_seq import arith_pkg::*; #(
  parameter int tamano = ARITH_W_DEFAULT
) (
  input  logic      CLOCK,
  input  logic      RESET,
  divi_seq_if.slave bus
);

  localparam int CNT_W = $clog2(tamano + 1);

  div_state_t        state;
  div_state_t        state_next;
  logic [tamano:0]   rem;
  logic [tamano-1:0] quo;
  logic [tamano-1:0] abs_b;
  logic              sign_a;
  logic              neg_q;
  logic [CNT_W-1:0]  count;
  logic [tamano:0]   rem_step;
  logic [tamano-1:0] quo_step;
  logic [tamano-1:0] abs_a_in;
  logic [tamano-1:0] abs_b_in;
  logic              b_zero;
  logic              last_step;
  logic              do_idle;
  logic              do_init;
  logic              do_step;
  logic              do_fix;
  logic              do_notify;

  // |-2^(tamano-1)| wraps to 2^(tamano-1), which is still correct read as unsigned.
  assign abs_a_in  = bus.A[tamano-1] ? -bus.A : bus.A;
  assign abs_b_in  = bus.B[tamano-1] ? -bus.B : bus.B;
  assign b_zero    = (bus.B == '0);
  assign last_step = (count == CNT_W'(tamano - 1));

  divi_step #(.tamano(tamano)) u_step (
    .rem      (rem),
    .quo      (quo),
    .abs_b    (abs_b),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.START) state_next = INIT;
      INIT:    state_next = b_zero ? NOTIFY : OP;
      OP:      if (last_step) state_next = FIX;
      FIX:     state_next = NOTIFY;
      NOTIFY:  if (!bus.START) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    do_idle   = 1'b0;
    do_init   = 1'b0;
    do_step   = 1'b0;
    do_fix    = 1'b0;
    do_notify = 1'b0;
    case (state)
      IDLE:    do_idle   = 1'b1;
      INIT:    do_init   = 1'b1;
      OP:      do_step   = 1'b1;
      FIX:     do_fix    = 1'b1;
      NOTIFY:  do_notify = 1'b1;
      default: do_idle   = 1'b1;
    endcase
  end

  // quo starts out holding |A| so its MSBs stream into rem as quotient bits fill the LSBs.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rem          <= '0;
      quo          <= '0;
      abs_b        <= '0;
      sign_a       <= 1'b0;
      neg_q        <= 1'b0;
      count        <= '0;
      bus.Q        <= '0;
      bus.R        <= '0;
      bus.END_DIV  <= 1'b0;
      bus.DIV_ZERO <= 1'b0;
    end else begin
      if (do_idle) bus.END_DIV <= 1'b0;
      if (do_init) begin
        quo    <= abs_a_in;
        abs_b  <= abs_b_in;
        sign_a <= bus.A[tamano-1];
        neg_q  <= bus.A[tamano-1] ^ bus.B[tamano-1];
        rem    <= '0;
        count  <= '0;
        if (b_zero) begin
          bus.Q        <= '1;
          bus.R        <= bus.A;
          bus.DIV_ZERO <= 1'b1;
        end else begin
          bus.DIV_ZERO <= 1'b0;
        end
      end
      if (do_step) begin
        rem   <= rem_step;
        quo   <= quo_step;
        count <= count + CNT_W'(1);
      end
      if (do_fix) begin
        bus.Q <= neg_q  ? -quo : quo;
        bus.R <= sign_a ? -rem[tamano-1:0] : rem[tamano-1:0];
      end
      if (do_notify) bus.END_DIV <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divi_seq.sv
// Self-checking bench for divi_seq: scoreboard of reference results, directed cases plus random sweep.
module tb_divi_seq;
  import arith_pkg::*;

  localparam int W = ARITH_W_DEFAULT;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic [7:0]   lat;
  } exp_t;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   vecCount = 0;
  int   missCount = 0;
  exp_t sb[$];

  divi_seq_if #(.tamano(W)) bus ();

  divi_seq #(.tamano(W)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Reference built on the simulator's own truncating signed division.
  function automatic exp_t refModel(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    exp_t e;
    int   ai, bi, q, r;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = -1;
      r = ai;
    end else begin
      q = ai / bi;
      r = ai - q * bi;
    end
    e.q   = q[W-1:0];
    e.r   = r[W-1:0];
    e.dz  = (bi == 0);
    e.lat = (bi == 0) ? 8'd3 : 8'(W + 4);
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit scramble, input bit holdStart);
    exp_t e;
    int   edges;
    sb.push_back(refModel(a, b));
    @(negedge CLOCK);
    bus.A     = a;
    bus.B     = b;
    bus.START = 1'b1;
    edges     = 0;
    do begin
      @(posedge CLOCK);
      edges++;
      @(negedge CLOCK);
      if (scramble && edges == 4) begin
        bus.A = W'($urandom);
        bus.B = W'($urandom);
      end
    end while (!bus.END_DIV && edges < 40);
    e = sb.pop_front();
    checkOutput("latency", 32'(edges), 32'(e.lat));
    checkOutput("Q", 32'(bus.Q), 32'(e.q));
    checkOutput("R", 32'(bus.R), 32'(e.r));
    checkOutput("DIV_ZERO", 32'(bus.DIV_ZERO), 32'(e.dz));
    if (holdStart) begin
      repeat (5) @(negedge CLOCK);
      checkOutput("END_DIV_hold", 32'(bus.END_DIV), 32'd1);
      checkOutput("Q_hold", 32'(bus.Q), 32'(e.q));
      checkOutput("state_hold", 32'(dut.state), 32'(NOTIFY));
    end
    bus.START = 1'b0;
    repeat (2) @(negedge CLOCK);
    checkOutput("END_DIV_low", 32'(bus.END_DIV), 32'd0);
    checkOutput("Q_keep", 32'(bus.Q), 32'(e.q));
  endtask

  task automatic resetMidOp();
    @(negedge CLOCK);
    bus.A     = 8'd100;
    bus.B     = 8'd7;
    bus.START = 1'b1;
    repeat (6) @(posedge CLOCK);
    #1 RESET = 1'b0;
    #1;
    checkOutput("rst_Q", 32'(bus.Q), 32'd0);
    checkOutput("rst_R", 32'(bus.R), 32'd0);
    checkOutput("rst_END_DIV", 32'(bus.END_DIV), 32'd0);
    checkOutput("rst_DIV_ZERO", 32'(bus.DIV_ZERO), 32'd0);
    checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
    bus.START = 1'b0;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;
  endtask

  initial begin
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #2 RESET = 1'b0;
    #3;
    checkOutput("init_Q", 32'(bus.Q), 32'd0);
    checkOutput("init_R", 32'(bus.R), 32'd0);
    checkOutput("init_END_DIV", 32'(bus.END_DIV), 32'd0);
    checkOutput("init_DIV_ZERO", 32'(bus.DIV_ZERO), 32'd0);
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;

    applyStimulus(8'd100, 8'd7, 1'b0, 1'b0);
    applyStimulus(-8'sd100, 8'd7, 1'b0, 1'b0);
    applyStimulus(8'd100, -8'sd7, 1'b0, 1'b0);
    applyStimulus(-8'sd100, -8'sd7, 1'b0, 1'b0);
    applyStimulus(8'd37, 8'd0, 1'b0, 1'b0);
    applyStimulus(8'd9, 8'd3, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'd1, 1'b0, 1'b0);
    applyStimulus(8'd5, 8'd9, 1'b0, 1'b0);
    applyStimulus(8'd127, 8'd127, 1'b0, 1'b0);
    applyStimulus(8'd77, 8'd5, 1'b0, 1'b1);
    applyStimulus(-8'sd123, 8'd10, 1'b1, 1'b0);

    resetMidOp();
    applyStimulus(-8'sd50, 8'd6, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
